// File: rtl/sha3_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sha3_pkg
//  Purpose  : Shared types and constants for the SHA-3 squeeze datapath:
//             lane/state types, lane geometry and the squeeze FSM encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package sha3_pkg;

    localparam int LANE_W    = 64;
    localparam int NUM_LANES = 25;

    typedef logic [LANE_W-1:0]           lane_t;
    typedef logic [LANE_W*NUM_LANES-1:0] state_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        PERM   = 2'd2,
        FIN    = 2'd3
    } sq_state_t;

endpackage
`default_nettype wire

// File: rtl/sha3_lane_mux.sv
`default_nettype none
// ============================================================================
//  Module   : sha3_lane_mux
//  Purpose  : Combinational selector of Keccak lane (x,y) from a 1600-bit
//             state; lane (x,y) lives at bits [64*(x+5y) +: 64].
//  Ports    : i_state - full Keccak state
//             i_x     - lane column (0..4)
//             i_y     - lane row    (0..4)
//             o_lane  - selected 64-bit lane (zero for indices past 24)
//  Revision : 1.0 - initial release
// ============================================================================
module sha3_lane_mux
    import sha3_pkg::*;
(
    input  state_t     i_state,
    input  logic [2:0] i_x,
    input  logic [2:0] i_y,
    output lane_t      o_lane
);

    logic [5:0] w_idx;

    always_comb begin
        w_idx  = {3'b000, i_x} + ({3'b000, i_y} * 6'd5);
        o_lane = '0;
        // Guard keeps the part-select inside the 25-lane state.
        if (w_idx < 6'(NUM_LANES)) begin
            o_lane = i_state[{w_idx, 6'b000000} +: LANE_W];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sha3_squeeze.sv
`default_nettype none
// ============================================================================
//  Module   : sha3_squeeze
//  Purpose  : Streams OUT_LANES 64-bit lanes out of a Keccak state over a
//             valid/ready interface, requesting a permutation each time the
//             RATE_LANES readable lanes of the current block are used up.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             start, state_in   - squeeze request and the state to squeeze
//             busy              - FSM not idle
//             out_valid/ready   - lane handshake, out_data/out_last payload
//             perm_req/perm_done- permutation handshake (state_in reloaded)
//             done              - one-cycle completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module sha3_squeeze
    import sha3_pkg::*;
#(
    parameter int RATE_LANES = 17,
    parameter int OUT_LANES  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [LANE_W*NUM_LANES-1:0] state_in,
    output logic                        busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANE_W-1:0]           out_data,
    output logic                        out_last,
    output logic                        perm_req,
    input  logic                        perm_done,
    output logic                        done
);

    generate
        if (RATE_LANES < 1 || RATE_LANES > NUM_LANES) begin : g_bad_rate
            $error("sha3_squeeze: RATE_LANES must be within 1..25");
        end
        if (OUT_LANES < 1 || OUT_LANES > 255) begin : g_bad_out
            $error("sha3_squeeze: OUT_LANES must be within 1..255");
        end
    endgenerate

    localparam logic [7:0] c_last_idx = 8'(OUT_LANES - 1);
    localparam logic [5:0] c_rate_end = 6'(RATE_LANES - 1);

    sq_state_t  r_fsm;
    state_t     r_state;
    logic [2:0] r_x;
    logic [2:0] r_y;
    logic [7:0] r_emitted;
    logic       r_out_valid;
    logic       r_out_last;
    logic       r_perm_req;
    logic       r_done;
    logic       r_busy;

    logic [5:0] w_pos;
    logic       w_beat;
    lane_t      w_lane;

    assign w_pos  = {3'b000, r_x} + ({3'b000, r_y} * 6'd5);
    assign w_beat = r_out_valid & out_ready;

    sha3_lane_mux u_lane_mux (
        .i_state (r_state),
        .i_x     (r_x),
        .i_y     (r_y),
        .o_lane  (w_lane)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= IDLE;
            r_state     <= '0;
            r_x         <= 3'd0;
            r_y         <= 3'd0;
            r_emitted   <= 8'd0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_perm_req  <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (start) begin
                        r_state     <= state_in;
                        r_x         <= 3'd0;
                        r_y         <= 3'd0;
                        r_emitted   <= 8'd0;
                        r_out_valid <= 1'b1;
                        r_out_last  <= (c_last_idx == 8'd0);
                        r_busy      <= 1'b1;
                        r_fsm       <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_beat) begin
                        r_emitted <= r_emitted + 8'd1;
                        if (r_out_last) begin
                            // Final lane wins over a coinciding rate boundary.
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_done      <= 1'b1;
                            r_fsm       <= FIN;
                        end else begin
                            // out_last is precomputed for the lane that follows.
                            r_out_last <= ((r_emitted + 8'd1) == c_last_idx);
                            if (w_pos == c_rate_end) begin
                                // Rate exhausted: park at (0,0) so x+5y stays in range.
                                r_out_valid <= 1'b0;
                                r_perm_req  <= 1'b1;
                                r_x         <= 3'd0;
                                r_y         <= 3'd0;
                                r_fsm       <= PERM;
                            end else if (r_x == 3'd4) begin
                                r_x <= 3'd0;
                                r_y <= r_y + 3'd1;
                            end else begin
                                r_x <= r_x + 3'd1;
                            end
                        end
                    end
                end
                PERM: begin
                    if (perm_done) begin
                        r_state     <= state_in;
                        r_x         <= 3'd0;
                        r_y         <= 3'd0;
                        r_perm_req  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_fsm       <= STREAM;
                    end
                end
                FIN: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    r_fsm  <= IDLE;
                end
                default: begin
                    r_fsm <= IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_data  = w_lane;
    // The look-ahead last flag is only meaningful alongside a valid lane.
    assign out_last  = r_out_last & r_out_valid;
    assign perm_req  = r_perm_req;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sha3_squeeze.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sha3_squeeze
//  Purpose  : Self-checking bench for sha3_squeeze. Three instances run in
//             lock-step: defaults (17,4), (17,20) with one permutation, and
//             (4,4) where the last lane meets the rate boundary.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sha3_squeeze;
    import sha3_pkg::*;

    localparam int NDUT = 3;

    function automatic int rl(input int g);
        case (g)
            0:       return 17;
            1:       return 17;
            default: return 4;
        endcase
    endfunction

    function automatic int ol(input int g);
        case (g)
            0:       return 4;
            1:       return 20;
            default: return 4;
        endcase
    endfunction

    // Lane i of block b: low word is 100*b+i, high word is seed-dependent noise.
    function automatic logic [63:0] lane_val(input int unsigned s, input int b, input int i);
        logic [31:0] hi;
        hi = (s == 0) ? 32'd0 : (s ^ (32'(i) * 32'h9E3779B9) ^ 32'(b << 16));
        return {hi, 32'(b * 100 + i)};
    endfunction

    function automatic logic [1599:0] make_state(input int unsigned s, input int b);
        logic [1599:0] st;
        for (int i = 0; i < 25; i++) st[64*i +: 64] = lane_val(s, b, i);
        return st;
    endfunction

    // Reference: the k-th emitted lane is lane (k mod rate) of block (k / rate).
    function automatic logic [63:0] exp_lane(input int g, input int k, input int unsigned s);
        return lane_val(s, k / rl(g), k % rl(g));
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start;
    logic          out_ready;
    logic [1599:0] st_in [NDUT];
    logic          pd    [NDUT];
    logic          busy  [NDUT];
    logic          ov    [NDUT];
    logic          olst  [NDUT];
    logic          pr    [NDUT];
    logic          dn    [NDUT];
    logic [63:0]   od    [NDUT];

    int unsigned seed;
    int          perm_lat;
    int          blk       [NDUT];
    int          pcnt      [NDUT];
    int          k         [NDUT];
    int          ndone     [NDUT];
    int          nperm     [NDUT];
    int          start_cyc [NDUT];
    int          done_cyc  [NDUT];
    logic        prev_req  [NDUT];
    logic        prev_done [NDUT];
    int          cyc;
    int          n_pass  = 0;
    int          n_total = 0;

    generate
        for (genvar g = 0; g < NDUT; g++) begin : g_dut
            assign st_in[g] = make_state(seed, blk[g]);
            sha3_squeeze #(
                .RATE_LANES (rl(g)),
                .OUT_LANES  (ol(g))
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .start     (start),
                .state_in  (st_in[g]),
                .busy      (busy[g]),
                .out_valid (ov[g]),
                .out_ready (out_ready),
                .out_data  (od[g]),
                .out_last  (olst[g]),
                .perm_req  (pr[g]),
                .perm_done (pd[g]),
                .done      (dn[g])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Permutation responder: perm_done after perm_lat cycles of perm_req,
    // presenting the next block on state_in at the same time.
    initial begin
        for (int g = 0; g < NDUT; g++) begin
            pd[g] = 1'b0; blk[g] = 0; pcnt[g] = 0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < NDUT; g++) begin
                pd[g] = 1'b0;
                if (!busy[g]) blk[g] = 0;
                if (pr[g] && !rst) begin
                    pcnt[g]++;
                    if (pcnt[g] == perm_lat) begin
                        blk[g]++;
                        pd[g] = 1'b1;
                    end
                end else begin
                    pcnt[g] = 0;
                end
            end
        end
    end

    // Scoreboard: checks every presented lane against the reference.
    initial begin
        cyc = 0;
        for (int g = 0; g < NDUT; g++) begin
            k[g] = 0; ndone[g] = 0; nperm[g] = 0; start_cyc[g] = 0; done_cyc[g] = 0;
            prev_req[g] = 1'b0; prev_done[g] = 1'b0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int g = 0; g < NDUT; g++) begin
                if (!rst) begin
                    if (start && !busy[g]) begin
                        k[g] = 0;
                        start_cyc[g] = cyc;
                    end
                    if (ov[g]) begin
                        check($sformatf("d%0d data k=%0d", g, k[g]), od[g], exp_lane(g, k[g], seed));
                        check($sformatf("d%0d last k=%0d", g, k[g]), 64'(olst[g]), 64'(k[g] == ol(g) - 1));
                        if (out_ready) k[g]++;
                    end
                    if (pr[g]) begin
                        check($sformatf("d%0d valid_in_perm", g), 64'(ov[g]), 64'd0);
                        if (!prev_req[g]) begin
                            nperm[g]++;
                            check($sformatf("d%0d perm_at_boundary k=%0d", g, k[g]),
                                  64'((k[g] > 0) && (k[g] % rl(g) == 0)), 64'd1);
                        end
                    end
                    if (dn[g]) begin
                        check($sformatf("d%0d done_beats", g), 64'(k[g]), 64'(ol(g)));
                        check($sformatf("d%0d done_width", g), 64'(prev_done[g]), 64'd0);
                        ndone[g]++;
                        done_cyc[g] = cyc;
                    end
                end
                prev_req[g]  = rst ? 1'b0 : pr[g];
                prev_done[g] = rst ? 1'b0 : dn[g];
            end
        end
    end

    function automatic logic ready_val(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 3 == 0);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // One squeeze on all instances; mode selects the out_ready pattern.
    task automatic run(input int unsigned s, input int mode, input bit mid_start, input bit chk_time);
        int  base_d [NDUT];
        int  base_p [NDUT];
        int  c;
        bit  all;
        seed = s;
        for (int g = 0; g < NDUT; g++) begin
            base_d[g] = ndone[g];
            base_p[g] = nperm[g];
        end
        @(posedge clk); #1;
        start     = 1'b1;
        out_ready = ready_val(mode, 0);
        c   = 0;
        all = 1'b0;
        while (!all && c < 2000) begin
            @(posedge clk); #1;
            c++;
            start     = (mid_start && c == 2);
            out_ready = ready_val(mode, c);
            all = 1'b1;
            for (int g = 0; g < NDUT; g++) if (ndone[g] == base_d[g]) all = 1'b0;
        end
        start     = 1'b0;
        out_ready = 1'b0;
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("d%0d done_count", g), 64'(ndone[g] - base_d[g]), 64'd1);
            if (chk_time) begin
                check($sformatf("d%0d perm_count", g), 64'(nperm[g] - base_p[g]),
                      64'((ol(g) - 1) / rl(g)));
                check($sformatf("d%0d start_to_done", g), 64'(done_cyc[g] - start_cyc[g]),
                      64'(ol(g) + 1 + ((ol(g) - 1) / rl(g)) * perm_lat));
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int base_d [NDUT];
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; seed = 0; perm_lat = 5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("d%0d rst out_valid", g), 64'(ov[g]), 64'd0);
            check($sformatf("d%0d rst out_last", g), 64'(olst[g]), 64'd0);
            check($sformatf("d%0d rst out_data", g), od[g], 64'd0);
            check($sformatf("d%0d rst perm_req", g), 64'(pr[g]), 64'd0);
            check($sformatf("d%0d rst done", g), 64'(dn[g]), 64'd0);
            check($sformatf("d%0d rst busy", g), 64'(busy[g]), 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed: lane i = i, perm block lane i = 100+i, full throughput.
        run(0, 0, 1'b0, 1'b1);
        // Directed: 1,0,0 ready pattern, lanes held through stalls.
        run(0, 1, 1'b0, 1'b0);
        // Start pulse during STREAM must be ignored; timing stays exact.
        run(32'h1234_5678, 0, 1'b1, 1'b1);

        // Reset after beat 1 abandons the squeeze without a done pulse.
        seed = 32'hCAFE_0001;
        for (int g = 0; g < NDUT; g++) base_d[g] = ndone[g];
        @(posedge clk); #1;
        start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("d%0d abort out_valid", g), 64'(ov[g]), 64'd0);
            check($sformatf("d%0d abort busy", g), 64'(busy[g]), 64'd0);
        end
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        for (int g = 0; g < NDUT; g++)
            check($sformatf("d%0d abort no_done", g), 64'(ndone[g] - base_d[g]), 64'd0);
        run(32'hCAFE_0002, 0, 1'b0, 1'b1);

        // Randomized data, backpressure and permutation latency.
        for (int r = 0; r < 6; r++) begin
            perm_lat = int'($urandom_range(1, 8));
            run($urandom | 32'd1, 2, r[0], 1'b0);
        end
        perm_lat = int'($urandom_range(1, 8));
        run($urandom | 32'd1, 0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
